// File: rtl/aes_stream_demux.sv
// aes_stream_demux: packet-atomic 1:M_COUNT AXI-Stream demultiplexer.
// The destination is sampled from sel on the first beat of each packet and held until tlast.
// Output stage: one registered slice plus a one-entry skid buffer, shared by all channels.
// Optional build macro AES_STREAM_DEMUX_DROP_EN: an out-of-range sel drops the whole packet
// and pulses drop_pkt. Without the macro, an out-of-range sel is clamped to channel M_COUNT-1.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   sel              destination channel, sampled on the first beat of a packet
//   busy             high while a packet is in flight
//   cur_sel          channel latched for the current or most recent packet
//   s_axis_*         input stream (tdata/tvalid/tready/tlast)
//   m_axis_*         output streams, packed per channel (channel i at [i*DATA_W +: DATA_W])
//   drop_pkt         (macro only) one-clk pulse after a dropped packet's tlast is accepted
module aes_stream_demux #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned M_COUNT = 2,
    parameter int unsigned SEL_W   = $clog2(M_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEL_W-1:0]            sel,
    output logic                        busy,
    output logic [SEL_W-1:0]            cur_sel,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [M_COUNT*DATA_W-1:0]   m_axis_tdata,
    output logic [M_COUNT-1:0]          m_axis_tvalid,
    input  logic [M_COUNT-1:0]          m_axis_tready,
`ifdef AES_STREAM_DEMUX_DROP_EN
    output logic                        drop_pkt,
`endif
    output logic [M_COUNT-1:0]          m_axis_tlast
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    state_t                      r_state, w_state_nxt;
    logic [SEL_W-1:0]            r_route, w_route_nxt;
    logic                        r_busy;
    logic                        r_s_tready;
    logic                        r_drop_pkt, w_drop_done;

    logic [M_COUNT-1:0]          r_m_tvalid, w_mv_nxt;
    logic [M_COUNT*DATA_W-1:0]   r_m_tdata,  w_md_nxt;
    logic [M_COUNT-1:0]          r_m_tlast,  w_ml_nxt;

    logic                        r_sk_valid, w_sk_valid_nxt;
    logic [DATA_W-1:0]           r_sk_data,  w_sk_data_nxt;
    logic                        r_sk_last,  w_sk_last_nxt;
    logic [SEL_W-1:0]            r_sk_route, w_sk_route_nxt;

    logic                        w_in_fire, w_out_fire, w_out_free, w_push;
    logic                        w_sel_oob;
    logic [SEL_W-1:0]            w_sel_clamp, w_beat_route;
    logic                        w_ld_en, w_ld_last;
    logic [SEL_W-1:0]            w_ld_route;
    logic [DATA_W-1:0]           w_ld_data;

    assign w_in_fire   = s_axis_tvalid && r_s_tready;
    assign w_out_fire  = |(r_m_tvalid & m_axis_tready);
    assign w_out_free  = !(|r_m_tvalid) || w_out_fire;
    assign w_sel_oob   = 32'(sel) >= M_COUNT;
    assign w_sel_clamp = w_sel_oob ? SEL_W'(M_COUNT - 1) : sel;

    // Packet framing FSM: route is latched on the first beat and frozen until tlast.
    always_comb begin
        w_state_nxt  = r_state;
        w_route_nxt  = r_route;
        w_beat_route = r_route;
        w_push       = w_in_fire;
        w_drop_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_in_fire) begin
`ifdef AES_STREAM_DEMUX_DROP_EN
                    if (w_sel_oob) begin
                        w_push      = 1'b0;
                        w_route_nxt = sel;
                        if (s_axis_tlast) w_drop_done = 1'b1;
                        else              w_state_nxt = ST_DROP;
                    end else begin
                        w_route_nxt  = w_sel_clamp;
                        w_beat_route = w_sel_clamp;
                        if (!s_axis_tlast) w_state_nxt = ST_ACTIVE;
                    end
`else
                    w_route_nxt  = w_sel_clamp;
                    w_beat_route = w_sel_clamp;
                    if (!s_axis_tlast) w_state_nxt = ST_ACTIVE;
`endif
                end
            end
            ST_ACTIVE: begin
                if (w_in_fire && s_axis_tlast) w_state_nxt = ST_IDLE;
            end
`ifdef AES_STREAM_DEMUX_DROP_EN
            ST_DROP: begin
                w_push = 1'b0;
                if (w_in_fire && s_axis_tlast) begin
                    w_state_nxt = ST_IDLE;
                    w_drop_done = 1'b1;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output slice + skid: skid always has priority when the slice frees up, preserving order.
    always_comb begin
        w_sk_valid_nxt = r_sk_valid;
        w_sk_data_nxt  = r_sk_data;
        w_sk_last_nxt  = r_sk_last;
        w_sk_route_nxt = r_sk_route;
        w_ld_en        = w_out_free && (r_sk_valid || w_push);
        w_ld_route     = r_sk_valid ? r_sk_route : w_beat_route;
        w_ld_data      = r_sk_valid ? r_sk_data  : s_axis_tdata;
        w_ld_last      = r_sk_valid ? r_sk_last  : s_axis_tlast;
        w_mv_nxt       = r_m_tvalid;
        w_md_nxt       = r_m_tdata;
        w_ml_nxt       = r_m_tlast;
        if (w_out_free) begin
            w_mv_nxt       = '0;
            w_md_nxt       = '0;
            w_ml_nxt       = '0;
            w_sk_valid_nxt = 1'b0;
            for (int unsigned i = 0; i < M_COUNT; i++) begin
                if (w_ld_en && (i == 32'(w_ld_route))) begin
                    w_mv_nxt[i]                 = 1'b1;
                    w_md_nxt[i*DATA_W +: DATA_W] = w_ld_data;
                    w_ml_nxt[i]                 = w_ld_last;
                end
            end
        end else if (w_push) begin
            w_sk_valid_nxt = 1'b1;
            w_sk_data_nxt  = s_axis_tdata;
            w_sk_last_nxt  = s_axis_tlast;
            w_sk_route_nxt = w_beat_route;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_route    <= '0;
            r_busy     <= 1'b0;
            r_s_tready <= 1'b0;
            r_drop_pkt <= 1'b0;
            r_m_tvalid <= '0;
            r_m_tdata  <= '0;
            r_m_tlast  <= '0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
            r_sk_last  <= 1'b0;
            r_sk_route <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_route    <= w_route_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_s_tready <= !w_sk_valid_nxt;
            r_drop_pkt <= w_drop_done;
            r_m_tvalid <= w_mv_nxt;
            r_m_tdata  <= w_md_nxt;
            r_m_tlast  <= w_ml_nxt;
            r_sk_valid <= w_sk_valid_nxt;
            r_sk_data  <= w_sk_data_nxt;
            r_sk_last  <= w_sk_last_nxt;
            r_sk_route <= w_sk_route_nxt;
        end
    end

    assign busy          = r_busy;
    assign cur_sel       = r_route;
    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tlast  = r_m_tlast;
`ifdef AES_STREAM_DEMUX_DROP_EN
    assign drop_pkt      = r_drop_pkt;
`else
    logic w_unused;
    assign w_unused = r_drop_pkt;
`endif

endmodule
